// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front end.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_e;

  // Stopwatch channel assignment.
  localparam int unsigned BTN_RUN   = 0;
  localparam int unsigned BTN_PAUSE = 1;
  localparam int unsigned BTN_CLEAR = 2;

  // Number of bits needed to hold the value itself, so a counter can reach its target.
  function automatic int unsigned clog2_width(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((value >> w) != 0) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, press/release pulses.
// Long-press pulse is built only with BUTTON_CONDITIONER_LONG_PRESS_EN defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYCLES = 10
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level_out,
  output logic press_out,
  output logic release_out,
  output logic long_out
);

  localparam int unsigned   CW         = clog2_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_TARGET) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_TARGET) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Level is registered off the next state so it moves with the pulse.
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int unsigned   HW          = clog2_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_TARGET = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          long_q, long_d;

  // Saturating at the target makes the pulse fire at most once per press.
  always_comb begin
    hold_inc = hold_q + HW'(1);
    hold_d   = hold_q;
    long_d   = 1'b0;
    if ((state_d == IDLE) || ((state_q == PRESS_WAIT) && (state_d == HELD))) begin
      hold_d = '0;
    end else if ((state_q == HELD) && (state_d == HELD) && (hold_q != HOLD_TARGET)) begin
      hold_d = hold_inc;
      long_d = (hold_inc == HOLD_TARGET);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_out = long_q;
`else
  assign long_out = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch push-button front end: polarity normalization plus one debounce channel per button.
// Optional long-press pulse via BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BTN_ACTIVE_HIGH = 1,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic                clkIn,
  input  logic                rstIn,
  input  logic [NUM_BTNS-1:0] btnRawIn,
  output logic [NUM_BTNS-1:0] btnLevelOut,
  output logic [NUM_BTNS-1:0] btnPressOut,
  output logic [NUM_BTNS-1:0] btnReleaseOut,
  output logic [NUM_BTNS-1:0] btnLongOut
);

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 32'h00FF_FFFF)) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic [NUM_BTNS-1:0] btn_pressed;

  assign btn_pressed = (BTN_ACTIVE_HIGH != 0) ? btnRawIn : ~btnRawIn;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      ,
      .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_chan (
      .clk        (clkIn),
      .rst_n      (rstIn),
      .btn_in     (btn_pressed[i]),
      .level_out  (btnLevelOut[i]),
      .press_out  (btnPressOut[i]),
      .release_out(btnReleaseOut[i]),
      .long_out   (btnLongOut[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, 3 buttons).
module tb_button_conditioner;
  import button_pkg::*;

  localparam int unsigned NB    = 3;
  localparam int unsigned DEB   = 4;
  localparam int unsigned LONGC = 10;
  // Raw change driven after posedge n is first sampled at n+1; pulse follows edge (n+1)+DEB+2.
  localparam int unsigned LAT   = DEB + 3;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    int unsigned   cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;
  } exp_t;

  logic          clkIn = 1'b0;
  logic          rstIn;
  logic [NB-1:0] btnRawIn;
  logic [NB-1:0] btnLevelOut;
  logic [NB-1:0] btnPressOut;
  logic [NB-1:0] btnReleaseOut;
  logic [NB-1:0] btnLongOut;

  exp_t        sbq[$];
  int unsigned cyc    = 0;
  int unsigned tests  = 0;
  int unsigned failed = 0;
  logic        bounce_seq [6];

  button_conditioner #(
    .NUM_BTNS       (NB),
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_HIGH(1),
    .LONG_CYCLES    (LONGC)
  ) dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .btnRawIn     (btnRawIn),
    .btnLevelOut  (btnLevelOut),
    .btnPressOut  (btnPressOut),
    .btnReleaseOut(btnReleaseOut),
    .btnLongOut   (btnLongOut)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int unsigned at, input logic [NB-1:0] p,
                              input logic [NB-1:0] r, input logic [NB-1:0] l);
    exp_t e;
    e.cyc   = at;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic check_level(input string name, input logic [NB-1:0] exp);
    check(name, 32'(btnLevelOut), 32'(exp));
  endtask

  // Monitor: every pulse the DUT shows must match the next scoreboard entry.
  always @(negedge clkIn) begin
    exp_t e;
    if ((rstIn === 1'b1) && ((btnPressOut | btnReleaseOut | btnLongOut) != '0)) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 32'({btnPressOut, btnReleaseOut, btnLongOut}), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_press", 32'(btnPressOut), 32'(e.press));
        check("pulse_release", 32'(btnReleaseOut), 32'(e.rel));
        check("pulse_long", 32'(btnLongOut), 32'(e.lng));
      end
    end
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, m, r;
    bounce_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rstIn    = 1'b0;
    btnRawIn = '0;
    repeat (3) tick();
    check("rst_level", 32'(btnLevelOut), 32'd0);
    check("rst_press", 32'(btnPressOut), 32'd0);
    check("rst_release", 32'(btnReleaseOut), 32'd0);
    check("rst_long", 32'(btnLongOut), 32'd0);
    rstIn = 1'b1;
    repeat (3) tick();

    // 1: clean press and release on run
    n = cyc;
    btnRawIn[BTN_RUN] = 1'b1;
    expect_pulse(n + LAT, 3'b001, 3'b000, 3'b000);
    if (LONG_EN) expect_pulse(n + LAT + LONGC, 3'b000, 3'b000, 3'b001);
    wait_to(n + LAT - 1);
    check_level("s1_level_before", 3'b000);
    wait_to(n + LAT);
    check_level("s1_level_rise", 3'b001);
    wait_to(n + 20);
    check_level("s1_level_held", 3'b001);
    m = cyc;
    btnRawIn[BTN_RUN] = 1'b0;
    expect_pulse(m + LAT, 3'b000, 3'b001, 3'b000);
    wait_to(m + LAT - 1);
    check_level("s1_level_before_fall", 3'b001);
    wait_to(m + LAT);
    check_level("s1_level_fall", 3'b000);
    wait_to(m + LAT + 3);

    // 2: bounce rejected on pause
    for (int i = 0; i < 6; i++) begin
      btnRawIn[BTN_PAUSE] = bounce_seq[i];
      tick();
      check_level("s2_level_bounce", 3'b000);
    end
    btnRawIn[BTN_PAUSE] = 1'b0;
    repeat (10) tick();
    check_level("s2_level_after", 3'b000);

    // 3: release with a one-cycle glitch on clear
    n = cyc;
    btnRawIn[BTN_CLEAR] = 1'b1;
    expect_pulse(n + LAT, 3'b100, 3'b000, 3'b000);
    wait_to(n + 10);
    check_level("s3_level_held", 3'b100);
    m = cyc;
    btnRawIn[BTN_CLEAR] = 1'b0;
    tick();
    tick();
    btnRawIn[BTN_CLEAR] = 1'b1;
    tick();
    btnRawIn[BTN_CLEAR] = 1'b0;
    expect_pulse(m + 10, 3'b000, 3'b100, 3'b000);
    wait_to(m + 5);
    check_level("s3_level_glitch", 3'b100);
    wait_to(m + 9);
    check_level("s3_level_before_fall", 3'b100);
    wait_to(m + 10);
    check_level("s3_level_fall", 3'b000);
    wait_to(m + 14);

    // 4: reset mid-debounce with clear already held
    n = cyc;
    btnRawIn = 3'b100;
    expect_pulse(n + LAT, 3'b100, 3'b000, 3'b000);
    wait_to(n + 10);
    m = cyc;
    btnRawIn[BTN_RUN] = 1'b1;
    wait_to(m + 3);
    check_level("s4_level_pre_reset", 3'b100);
    rstIn = 1'b0;
    #1;
    check("s4_reset_level", 32'(btnLevelOut), 32'd0);
    check("s4_reset_press", 32'(btnPressOut), 32'd0);
    check("s4_reset_release", 32'(btnReleaseOut), 32'd0);
    tick();
    tick();
    r = cyc;
    rstIn = 1'b1;
    expect_pulse(r + LAT, 3'b101, 3'b000, 3'b000);
    wait_to(r + LAT - 1);
    check_level("s4_level_before", 3'b000);
    wait_to(r + LAT);
    check_level("s4_level_rise", 3'b101);
    wait_to(r + 10);
    m = cyc;
    btnRawIn = 3'b000;
    expect_pulse(m + LAT, 3'b000, 3'b101, 3'b000);
    wait_to(m + LAT);
    check_level("s4_level_fall", 3'b000);
    wait_to(m + LAT + 3);

    // 5: simultaneous press on all channels
    n = cyc;
    btnRawIn = 3'b111;
    expect_pulse(n + LAT, 3'b111, 3'b000, 3'b000);
    if (LONG_EN) expect_pulse(n + LAT + LONGC, 3'b000, 3'b000, 3'b111);
    wait_to(n + LAT);
    check("s5_press_all", 32'(btnPressOut), 32'h7);
    wait_to(n + LAT + 1);
    check("s5_press_one_cycle", 32'(btnPressOut), 32'h0);
    wait_to(n + 20);
    m = cyc;
    btnRawIn = 3'b000;
    expect_pulse(m + LAT, 3'b000, 3'b111, 3'b000);
    wait_to(m + LAT + 3);
    check_level("s5_level_idle", 3'b000);

    // 6: long press on run
    n = cyc;
    btnRawIn[BTN_RUN] = 1'b1;
    expect_pulse(n + LAT, 3'b001, 3'b000, 3'b000);
    if (LONG_EN) expect_pulse(n + LAT + LONGC, 3'b000, 3'b000, 3'b001);
    wait_to(n + LAT + LONGC);
    check("s6_long_pulse", 32'(btnLongOut), LONG_EN ? 32'd1 : 32'd0);
    wait_to(n + LAT + LONGC + 1);
    check("s6_long_one_cycle", 32'(btnLongOut), 32'd0);
    wait_to(n + 30);
    m = cyc;
    btnRawIn[BTN_RUN] = 1'b0;
    expect_pulse(m + LAT, 3'b000, 3'b001, 3'b000);
    wait_to(m + LAT + 3);

    for (int i = 0; i < 50; i++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    check("scoreboard_drained", sbq.size(), 32'd0);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      $display("  pending pulse: cycle %0d press %b release %b long %b", e.cyc, e.press, e.rel, e.lng);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side front end for the stopwatch: turns raw, bouncing, asynchronous push-button levels into clean, clock-aligned signals for the control FSM.
- The control FSM's run, pause and clear inputs consume this block's one-cycle press pulses. The display path is output-only; this block is the matching input path.
- Each button gets a two-flop synchronizer, a debounce state machine, press/release edge pulses and a debounced level.

Parameters:
- NUM_BTNS, 3, number of independent button channels (bit 0 run, 1 pause, 2 clear in the stopwatch top).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change. Legal range is 2 to 2^24-1.
- BTN_ACTIVE_HIGH, 1, 1: raw pressed = 1; 0: raw pressed = 0. The input is inverted before the synchronizer.
- LONG_CYCLES, 50000000, hold time for a long-press pulse. Used only when the optional feature is compiled in. Must be greater than DEBOUNCE_CYCLES.

Ports:
- clkIn  input  1  system clock
- rstIn  input  1  reset; one clock; reset is asynchronous and active-low
- btnRawIn  input  NUM_BTNS  raw pad levels, asynchronous to clkIn
- btnLevelOut  output  NUM_BTNS  debounced pressed level (1 = pressed)
- btnPressOut  output  NUM_BTNS  one-cycle pulse on accepted press
- btnReleaseOut  output  NUM_BTNS  one-cycle pulse on accepted release
- btnLongOut  output  NUM_BTNS  one-cycle long-press pulse; tied 0 without the feature

Behaviour:
- Reset (rstIn=0, asynchronous): all synchronizer flops, counters and outputs go to 0, and every channel goes to IDLE. Deassertion of reset is not synchronized inside this block.
- Reset mid-operation aborts any in-progress debounce. No pulse is generated by reset itself.
- A button already held when reset deasserts is debounced as a fresh press and produces a btnPressOut pulse.
- Synchronizer: polarity-normalized raw input passes through 2 flops to give s.
- Counter width: clog2(DEBOUNCE_CYCLES) bits per channel. It saturates at its target and never wraps.
- Per-channel FSM:
  - IDLE: level=0. If s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: if s=0, return to IDLE (bounce rejected, no pulse). Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, go to HELD.
  - HELD: level=1. If s=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: level stays 1. If s=1, return to HELD (no pulse). Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Output timing:
  - PRESS_WAIT->HELD: btnPressOut is registered and high for exactly 1 cycle; btnLevelOut rises in the same cycle.
  - RELEASE_WAIT->IDLE: btnReleaseOut is high for exactly 1 cycle; btnLevelOut falls in the same cycle.
- Latency: take the first clkIn edge sampling raw pressed as edge 0, with a stable input. btnPressOut is high in the cycle following edge DEBOUNCE_CYCLES+2. Release latency is identical.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses; there is no arbitration.
- btnPressOut and btnReleaseOut are never both high on one channel.
- Minimum spacing between a press pulse and the next release pulse on a channel is DEBOUNCE_CYCLES+1 cycles.

Optional Feature:
- Macro: BUTTON_CONDITIONER_LONG_PRESS_EN.
- With the macro: each channel has a saturating hold counter, width clog2(LONG_CYCLES).
  - The counter is cleared on entry to HELD from PRESS_WAIT.
  - It counts only while in HELD and holds its value in RELEASE_WAIT.
  - It is cleared when the channel reaches IDLE.
  - When it reaches LONG_CYCLES, btnLongOut pulses 1 cycle. This happens at most once per press.
- Without the macro: no hold counter logic; btnLongOut is constant 0. The port list is unchanged.

Decomposition:
- Shared package button_pkg holds:
  - the state enum IDLE/PRESS_WAIT/HELD/RELEASE_WAIT (2-bit encoding);
  - a clog2 width helper function;
  - a default stopwatch channel index constant per button: run=0, pause=1, clear=2.
- Sub-module debounce_channel contains the synchronizer, FSM, counters and the optional long-press logic. It is instantiated NUM_BTNS times via generate.
- The top level does polarity normalization and bus packing only.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, NUM_BTNS=3):
1. Clean press: btnRawIn[0] rises at edge 0 and is held 20 cycles. Expect btnPressOut[0]=1 only in the cycle after edge 6, and btnLevelOut[0]=1 from then on. Other channels stay 0.
2. Bounce reject: raw[1] toggles 1,1,0,1,1,0 over 6 cycles, then stays 0. Expect no press pulse and btnLevelOut[1] stays 0.
3. Release with glitch: from HELD, raw[2] goes 0 for 2 cycles, 1 for 1 cycle, then 0 for 10 cycles. Expect a single btnReleaseOut[2] pulse 6 cycles after the final falling sample. Level falls in the same cycle.
4. Reset mid-debounce: raw[0] high, rstIn pulled low at cycle 3. Expect all outputs 0 immediately. After release of reset with raw still high, btnPressOut[0] pulses 6 cycles later.
5. Simultaneous: raw[2:0]=3'b111 at the same edge. Expect btnPressOut=3'b111 for exactly one cycle.
6. Long press, with macro defined: hold raw[0] 30 cycles. Expect btnLongOut[0] pulse exactly once, 10 cycles after btnPressOut[0]. Without the macro, btnLongOut stays 0.
